// File: rtl/mtx_wrseq.sv
// ---------------------------------------------------------------------------
// mtx_wrseq -- matrix result write sequencer
//
// Takes 32-bit accumulator results from the systolic multiply unit over a
// valid/ready handshake and writes each one to local RAM through a req/ack
// port. Addresses start at a loaded base and advance by 4 bytes (row-major)
// or by 4*width bytes (column-major). A one-cycle done pulse marks the end of
// the programmed element count.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   start              1-cycle pulse in IDLE: load base/width/colmaj/count
//   base [ADDR_W]      start byte address (bits [1:0] forced to 0)
//   width [4]          matrix width in elements, 0 means 16
//   colmaj             1 = column-major stride, 0 = row-major stride
//   count [CNT_W]      number of results to write, 0 = none
//   in_valid/in_data   result stream input
//   in_ready           sequencer accepts a result this cycle
//   wr_req/wr_addr/wr_data/wr_ack   local RAM write port (req held to ack)
//   busy               high whenever not IDLE
//   done               1-cycle pulse when the sequence completes
// ---------------------------------------------------------------------------
module mtx_wrseq #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [3:0]        width,
    input  logic              colmaj,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IN = 2'd1,
        S_WRITE   = 2'd2,
        S_FIN     = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic [6:0]          stride_q, stride_d;   // at most 64 bytes
    logic [CNT_W-1:0]    cnt_q,    cnt_d;

    logic [4:0]          width_elems;
    logic [ADDR_W-1:0]   stride_ext;

    // width=0 encodes a 16-element matrix
    assign width_elems = (width == 4'd0) ? 5'd16 : {1'b0, width};
    assign stride_ext  = {{(ADDR_W-7){1'b0}}, stride_q};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        stride_d = stride_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base & {{(ADDR_W-2){1'b1}}, 2'b00};
                    stride_d = colmaj ? {width_elems, 2'b00} : 7'd4;
                    cnt_d    = count;
                    state_d  = (count == '0) ? S_FIN : S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ack) begin
                    // address wraps modulo 2^ADDR_W; no carry kept
                    addr_d = addr_q + stride_ext;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    state_d = (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) ? S_FIN : S_WAIT_IN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            stride_q <= stride_d;
            cnt_q    <= cnt_d;
        end
    end

    // Handshake outputs decode from state alone, so in_ready never depends
    // on in_valid and wr_req drops on the same edge that takes the ack.
    assign in_ready = (state_q == S_WAIT_IN);
    assign wr_req   = (state_q == S_WRITE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;

endmodule

// File: tb/tb_mtx_wrseq.sv
// ---------------------------------------------------------------------------
// tb_mtx_wrseq -- directed self-checking bench for mtx_wrseq
// ---------------------------------------------------------------------------
module tb_mtx_wrseq;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [3:0]        width;
    logic              colmaj;
    logic [CNT_W-1:0]  count;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    mtx_wrseq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .width    (width),
        .colmaj   (colmaj),
        .count    (count),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // advance one clock, then settle 1 time unit past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [ADDR_W-1:0] b, input logic [3:0] w,
                      input logic cm, input logic [CNT_W-1:0] n);
        start = 1'b1; base = b; width = w; colmaj = cm; count = n;
        step();
        start = 1'b0;
    endtask

    // Feed one result, optionally stall the ack, then acknowledge it.
    task automatic elem(input string tag, input logic [31:0] d,
                        input logic [ADDR_W-1:0] a, input bit last, input int stall);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0; in_data = ~d;
        chk({tag, ".wr_req"},   64'(wr_req),   64'd1);
        chk({tag, ".wr_addr"},  64'(wr_addr),  64'(a));
        chk({tag, ".wr_data"},  64'(wr_data),  64'(d));
        chk({tag, ".in_ready0"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; in_data = 32'hBAD0_0000 + 32'(i);
            wr_ack = 1'b0;
            step();
            chk({tag, ".stall_req"},   64'(wr_req),   64'd1);
            chk({tag, ".stall_addr"},  64'(wr_addr),  64'(a));
            chk({tag, ".stall_data"},  64'(wr_data),  64'(d));
            chk({tag, ".stall_rdy"},   64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        chk({tag, ".req_drop"}, 64'(wr_req), 64'd0);
        if (last) begin
            chk({tag, ".done"},     64'(done),     64'd1);
            chk({tag, ".busy_fin"}, 64'(busy),     64'd1);
            chk({tag, ".rdy_fin"},  64'(in_ready), 64'd0);
            step();
            chk({tag, ".done_end"}, 64'(done), 64'd0);
            chk({tag, ".busy_end"}, 64'(busy), 64'd0);
        end else begin
            chk({tag, ".nodone"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base = '0; width = '0; colmaj = 1'b0;
        count = '0; in_valid = 1'b0; in_data = '0; wr_ack = 1'b0;
        step(); step();

        // reset state
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.wr_req",   64'(wr_req),   64'd0);
        chk("rst.busy",     64'(busy),     64'd0);
        chk("rst.done",     64'(done),     64'd0);
        chk("rst.wr_addr",  64'(wr_addr),  64'd0);
        chk("rst.wr_data",  64'(wr_data),  64'd0);
        reset = 1'b0;
        step();

        // row-major, 4 elements
        go(22'h100, 4'd4, 1'b0, 6'd4);
        chk("row.busy", 64'(busy), 64'd1);
        elem("row0", 32'hAAAA_0001, 22'h100, 1'b0, 0);
        elem("row1", 32'hBBBB_0002, 22'h104, 1'b0, 0);
        elem("row2", 32'hCCCC_0003, 22'h108, 1'b0, 0);
        elem("row3", 32'hDDDD_0004, 22'h10C, 1'b1, 0);

        // column-major width 3
        go(22'h200, 4'd3, 1'b1, 6'd3);
        elem("col0", 32'h1111_1111, 22'h200, 1'b0, 0);
        elem("col1", 32'h2222_2222, 22'h20C, 1'b0, 0);
        elem("col2", 32'h3333_3333, 22'h218, 1'b1, 0);

        // column-major width 0 -> stride 64
        go(22'h400, 4'd0, 1'b1, 6'd2);
        elem("w16_0", 32'h0000_4000, 22'h400, 1'b0, 0);
        elem("w16_1", 32'h0000_4040, 22'h440, 1'b1, 0);

        // ack stall of 5 cycles on element 2
        go(22'h500, 4'd2, 1'b0, 6'd3);
        elem("stl0", 32'h5000_0000, 22'h500, 1'b0, 0);
        elem("stl1", 32'h5000_0001, 22'h504, 1'b0, 5);
        elem("stl2", 32'h5000_0002, 22'h508, 1'b1, 0);

        // count=0: done next cycle, start held through FIN is ignored
        start = 1'b1; base = 22'h900; width = 4'd1; colmaj = 1'b0; count = 6'd0;
        step();
        chk("cnt0.done",   64'(done),   64'd1);
        chk("cnt0.wr_req", 64'(wr_req), 64'd0);
        count = 6'd5;
        step();
        start = 1'b0;
        chk("cnt0.done_end", 64'(done),   64'd0);
        chk("cnt0.idle",     64'(busy),   64'd0);
        chk("cnt0.noreq",    64'(wr_req), 64'd0);

        // reset while element 3 of 6 is pending
        go(22'h600, 4'd4, 1'b0, 6'd6);
        elem("rr0", 32'h6000_0000, 22'h600, 1'b0, 0);
        elem("rr1", 32'h6000_0001, 22'h604, 1'b0, 0);
        in_valid = 1'b1; in_data = 32'h6000_0002;
        step();
        in_valid = 1'b0;
        chk("rr2.wr_req", 64'(wr_req),  64'd1);
        chk("rr2.addr",   64'(wr_addr), 64'h608);
        reset = 1'b1; wr_ack = 1'b1;
        step();
        reset = 1'b0; wr_ack = 1'b0;
        chk("rr.wr_req",  64'(wr_req),  64'd0);
        chk("rr.busy",    64'(busy),    64'd0);
        chk("rr.done",    64'(done),    64'd0);
        chk("rr.addr",    64'(wr_addr), 64'd0);
        step();
        chk("rr.done2",   64'(done),    64'd0);
        go(22'h700, 4'd4, 1'b0, 6'd2);
        elem("rr_new0", 32'h7000_0000, 22'h700, 1'b0, 0);
        elem("rr_new1", 32'h7000_0001, 22'h704, 1'b1, 0);

        // address wrap, low base bits forced to 0
        go(22'h3FFFFF, 4'd4, 1'b0, 6'd2);
        elem("wrap0", 32'hFFFF_0000, 22'h3FFFFC, 1'b0, 0);
        elem("wrap1", 32'hFFFF_0001, 22'h000000, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
